// File: rtl/spi_frame_rx_if.sv
// Sample-pair handoff between the SPI frame receiver (master) and the filter core (slave).
// The pair is offered with sample_valid and consumed when sample_ready is high at a clock edge.
interface spi_frame_rx_if #(
  parameter int WORD_W = 14
);
  logic [WORD_W-1:0] sample_a;
  logic [WORD_W-1:0] sample_b;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_a,
    output sample_b,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_a,
    input  sample_b,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/spi_frame_rx.sv
// Oversampling SPI slave receiver: deserialises MSB-first words, locks onto the
// header/A/B frame and hands each sample pair to the filter core over valid/ready.
module spi_frame_rx #(
  parameter int                WORD_W      = 14,
  parameter logic [WORD_W-1:0] HEADER      = WORD_W'(14'h0FFF),
  parameter int                SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sck,
  input  logic           mosi,
  input  logic           cs,
  spi_frame_rx_if.master smp,
  output logic           overrun,
  output logic [7:0]     err_cnt
);

  localparam int CNT_W = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);

  typedef enum logic [1:0] {S_HUNT, S_WAIT_A, S_WAIT_B} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic [WORD_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_word_done;
  logic                   r_word_good;
  logic [WORD_W-1:0]      r_word;

  state_t                 r_state;
  logic [WORD_W-1:0]      r_a_hold;
  logic [WORD_W-1:0]      r_sample_a;
  logic [WORD_W-1:0]      r_sample_b;
  logic                   r_sample_valid;
  logic                   r_overrun;
  logic [7:0]             r_err_cnt;

  logic w_sck_s, w_mosi_s, w_cs_s;
  logic w_sck_rise, w_cs_fall, w_cs_rise;
  logic w_pair_done, w_err_evt, w_accept;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;

  // Pin front end: synchronise, detect edges, shift bits and latch the word on cs rise.
  // NOTE: every register here is assigned with <= so all flops see pre-edge values
  // and the synchroniser chain shifts by exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
      r_word_good <= 1'b0;
      r_word      <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
      r_word_done <= 1'b0;

      if (w_cs_fall) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise && !w_cs_s) begin
        r_shift <= {r_shift[WORD_W-2:0], w_mosi_s};
        if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end

      if (w_cs_rise) begin
        r_word_done <= 1'b1;
        r_word_good <= (r_bit_cnt == FULL_CNT);
        r_word      <= r_shift;
      end
    end
  end

  assign w_pair_done = r_word_done && r_word_good && (r_state == S_WAIT_B);
  assign w_err_evt   = r_word_done &&
                       (!r_word_good || ((r_state == S_HUNT) && (r_word != HEADER)));
  assign w_accept    = r_sample_valid && smp.sample_ready;

  // Frame FSM plus the output pair register; a new pair may replace one accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_HUNT;
      r_a_hold       <= '0;
      r_sample_a     <= '0;
      r_sample_b     <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_err_cnt      <= '0;
    end else begin
      if (r_word_done) begin
        case (r_state)
          S_HUNT: begin
            if (r_word_good && (r_word == HEADER)) r_state <= S_WAIT_A;
          end
          S_WAIT_A: begin
            if (r_word_good) begin
              r_a_hold <= r_word;
              r_state  <= S_WAIT_B;
            end else begin
              r_state  <= S_HUNT;
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end

      if (w_err_evt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;

      if (w_pair_done && (!r_sample_valid || w_accept)) begin
        r_sample_a     <= r_a_hold;
        r_sample_b     <= r_word;
        r_sample_valid <= 1'b1;
      end else begin
        if (w_pair_done) r_overrun      <= 1'b1;
        if (w_accept)    r_sample_valid <= 1'b0;
      end
    end
  end

  assign smp.sample_a     = r_sample_a;
  assign smp.sample_b     = r_sample_b;
  assign smp.sample_valid = r_sample_valid;
  assign overrun          = r_overrun;
  assign err_cnt          = r_err_cnt;

endmodule
